amm_copy_engine: RTL and testbench
==================================

Name: amm_copy_engine

Overview:
- CSR-programmed word-copy controller that sequences the Avalon-MM master port: reads LENGTH words from SRC and writes them to DST, one word in flight at a time.
- Host software programs it through an Avalon-MM slave CSR window over PCIe.
- Typical target is on-board SDRAM (e.g. 0x08000000 region).
- Raises a level interrupt on completion or abort.

Parameters:
- MASTER_ADDRESSWIDTH, 26: master byte-address width.
- SLAVE_ADDRESSWIDTH, 3: CSR word-address width (8 slots).
- DATAWIDTH, 32: data width of both ports; byte stride is DATAWIDTH/8.
- LENWIDTH, 16: width of the LENGTH and WORDS_DONE counters.

Ports:
- clk  in  1  single clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- slave_address  in  SLAVE_ADDRESSWIDTH  CSR index.
- slave_writedata  in  DATAWIDTH  CSR write data.
- slave_write  in  1  CSR write strobe.
- slave_read  in  1  CSR read strobe.
- slave_chipselect  in  1  qualifies slave_read and slave_write.
- slave_readdata  out  DATAWIDTH  registered CSR read data.
- master_address  out  MASTER_ADDRESSWIDTH  byte address.
- master_writedata  out  DATAWIDTH  write data.
- master_write  out  1  write request.
- master_read  out  1  read request.
- master_readdata  in  DATAWIDTH  returned read data.
- master_readdatavalid  in  1  read data valid.
- master_waitrequest  in  1  stalls the current request.
- irq  out  1  equals (DONE | ABORTED) & IRQ_EN.
- busy  out  1  high while FSM is not IDLE.

Behaviour:
- Reset (async assert, sync release): all outputs 0; all CSRs 0; FSM in IDLE.
- CSR map (word index):
  - 0 CTRL: bit0 START (write-1 pulse, reads 0); bit1 ABORT (write-1 pulse, reads 0); bit2 IRQ_EN (R/W).
  - 1 STATUS (RO): bit0 BUSY, bit1 DONE, bit2 ABORTED.
  - 2 SRC (R/W).
  - 3 DST (R/W).
  - 4 LENGTH in words (R/W, LENWIDTH bits).
  - 5 WORDS_DONE (RO).
  - 6 IRQ_CLR: write any value to clear DONE and ABORTED.
  - 7 ID (RO): constant 32'hC0DE0001.
- CSR access:
  - slave_readdata updates one cycle after a read with chipselect; otherwise it holds its value.
  - Unused bits read 0.
  - Writes to SRC, DST and LENGTH while BUSY=1 are ignored.
  - START while busy is ignored.
  - START clears DONE, ABORTED and WORDS_DONE.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH.
  - IDLE: on START, latch cur_src=SRC, cur_dst=DST, remaining=LENGTH. If LENGTH==0 go to FINISH, else go to RD_REQ.
  - RD_REQ: master_read=1, master_address=cur_src. Hold until master_waitrequest=0, then go to RD_WAIT.
  - RD_WAIT: on master_readdatavalid, capture master_readdata into the data register and go to WR_REQ.
  - WR_REQ: master_write=1, master_address=cur_dst, master_writedata=data. Hold until master_waitrequest=0. On acceptance: cur_src/cur_dst += DATAWIDTH/8; remaining -= 1; WORDS_DONE += 1. Then:
    - go to FINISH if remaining reaches 0 or an abort is pending;
    - otherwise go to RD_REQ.
  - FINISH: one cycle. Set DONE, or ABORTED if an abort was pending; clear the abort pending flag; go to IDLE.
- Requests and address/data stability:
  - master_read and master_write are never asserted together.
  - Address and data stay stable while waitrequest=1.
  - Request signals deassert in the cycle after acceptance.
- Abort:
  - An ABORT write sets abort_pending, which is honoured only at word boundaries.
  - A bus transaction is never cut mid-handshake; an in-flight read completes and its word is written.
  - ABORT while IDLE has no effect.
  - ABORT in the same cycle as the final word's acceptance reports DONE, not ABORTED.
- Addresses wrap modulo 2^MASTER_ADDRESSWIDTH. No alignment check: the low bits of SRC and DST are passed through unchanged.
- Throughput: minimum 3 cycles per word with zero waitrequest and read latency 1.
- Simultaneous CSR write and FSM update of the same status bit: the FSM set takes priority over IRQ_CLR.
- Reset mid-transfer: FSM to IDLE, requests drop immediately, CSRs return to reset values.

Decomposition:
- Package amm_copy_pkg holds:
  - state_t enum;
  - CSR index localparams (CSR_CTRL..CSR_ID);
  - CTRL/STATUS bit positions;
  - ID constant.
- One natural sub-module: amm_copy_csr, containing the register file, pulse generation, status set/clear and the readdata register.
- The FSM and address counters stay in the top-level module.

Test Plan:
- Basic copy: SRC=0x08000000, DST=0x08001000, LENGTH=4, IRQ_EN=1, START; memory model with zero wait. Required:
  - 4 reads at 0x08000000..0x0800000C;
  - 4 writes at 0x08001000..0x0800100C with matching data;
  - STATUS=0x2, WORDS_DONE=4, irq=1;
  - IRQ_CLR write drops irq.
- Backpressure: model holds waitrequest 3 cycles on every request and returns readdatavalid 5 cycles late. Required:
  - address and data stable throughout;
  - copy of LENGTH=2 is correct.
- Zero length: LENGTH=0, START. Required:
  - no master_read or master_write;
  - DONE set 2 cycles after START;
  - WORDS_DONE=0.
- Abort: LENGTH=100, ABORT written during the 3rd word's read. Required:
  - 3rd word is still written;
  - STATUS=0x4 (ABORTED), WORDS_DONE=3.
- Busy lockout and wrap:
  - Write SRC=0 while busy: register keeps its old value; START while busy is ignored.
  - DST=0x3FFFFFC, LENGTH=2: second write goes to 0x0000000.
- Async reset: assert reset_n=0 mid-WR_REQ. Required:
  - master_write=0 immediately, without waiting for a clock edge;
  - after release, STATUS=0 and ID reads 32'hC0DE0001.

Source files
------------

// File: rtl/amm_copy_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : amm_copy_pkg
//  Purpose  : Shared types and constants for the Avalon-MM word-copy engine:
//             FSM state encoding, CSR word indices, CTRL/STATUS bit positions
//             and the read-only identification value.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package amm_copy_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_FINISH  = 3'd4
   } state_t;

   // CSR word indices
   localparam int unsigned CSR_CTRL       = 0;
   localparam int unsigned CSR_STATUS     = 1;
   localparam int unsigned CSR_SRC        = 2;
   localparam int unsigned CSR_DST        = 3;
   localparam int unsigned CSR_LENGTH     = 4;
   localparam int unsigned CSR_WORDS_DONE = 5;
   localparam int unsigned CSR_IRQ_CLR    = 6;
   localparam int unsigned CSR_ID         = 7;

   // CTRL bit positions
   localparam int unsigned CTRL_START_BIT  = 0;
   localparam int unsigned CTRL_ABORT_BIT  = 1;
   localparam int unsigned CTRL_IRQ_EN_BIT = 2;

   // STATUS bit positions
   localparam int unsigned STAT_BUSY_BIT    = 0;
   localparam int unsigned STAT_DONE_BIT    = 1;
   localparam int unsigned STAT_ABORTED_BIT = 2;

   localparam logic [31:0] ID_VALUE = 32'hC0DE_0001;

endpackage : amm_copy_pkg
`default_nettype wire

// File: rtl/amm_copy_csr.sv
`default_nettype none
// ============================================================================
//  Module   : amm_copy_csr
//  Purpose  : Avalon-MM slave register file of the copy engine. Holds the
//             programmable SRC/DST/LENGTH/IRQ_EN registers, turns START and
//             ABORT writes into one-cycle pulses, keeps the DONE/ABORTED
//             sticky status bits and drives the registered read data.
//  Ports    : clk, reset_n           - clock, async active-low reset
//             slave_*                - CSR slave interface
//             busy_i                 - engine is not idle
//             set_done_i/aborted_i   - completion events from the engine
//             words_done_i           - progress counter for readback
//             start_o/abort_o        - one-cycle command pulses
//             irq_o                  - level interrupt
//             src_o/dst_o/length_o   - programmed transfer descriptor
//  Revision : 1.0 - initial release
// ============================================================================
module amm_copy_csr
   import amm_copy_pkg::*;
#(
   parameter int MASTER_ADDRESSWIDTH = 26,
   parameter int SLAVE_ADDRESSWIDTH  = 3,
   parameter int DATAWIDTH           = 32,
   parameter int LENWIDTH            = 16
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address,
   input  logic [DATAWIDTH-1:0]           slave_writedata,
   input  logic                           slave_write,
   input  logic                           slave_read,
   input  logic                           slave_chipselect,
   output logic [DATAWIDTH-1:0]           slave_readdata,
   input  logic                           busy_i,
   input  logic                           set_done_i,
   input  logic                           set_aborted_i,
   input  logic [LENWIDTH-1:0]            words_done_i,
   output logic                           start_o,
   output logic                           abort_o,
   output logic                           irq_o,
   output logic [MASTER_ADDRESSWIDTH-1:0] src_o,
   output logic [MASTER_ADDRESSWIDTH-1:0] dst_o,
   output logic [LENWIDTH-1:0]            length_o
);

   logic                           start_q, abort_q, irq_en_q, done_q, aborted_q;
   logic [MASTER_ADDRESSWIDTH-1:0] src_q, dst_q;
   logic [LENWIDTH-1:0]            length_q;
   logic [DATAWIDTH-1:0]           readdata_q, readdata_d;

   logic w_wr, w_rd, w_wr_ctrl, w_wr_src, w_wr_dst, w_wr_len, w_wr_clr;
   logic w_start_accepted;
   logic w_unused_wdata;

   assign w_wr      = slave_chipselect & slave_write;
   assign w_rd      = slave_chipselect & slave_read;
   assign w_wr_ctrl = w_wr && (slave_address == SLAVE_ADDRESSWIDTH'(CSR_CTRL));
   assign w_wr_src  = w_wr && (slave_address == SLAVE_ADDRESSWIDTH'(CSR_SRC));
   assign w_wr_dst  = w_wr && (slave_address == SLAVE_ADDRESSWIDTH'(CSR_DST));
   assign w_wr_len  = w_wr && (slave_address == SLAVE_ADDRESSWIDTH'(CSR_LENGTH));
   assign w_wr_clr  = w_wr && (slave_address == SLAVE_ADDRESSWIDTH'(CSR_IRQ_CLR));

   // The engine only acts on a START pulse while idle; the status clear
   // must follow the same rule so a rejected START leaves status intact.
   assign w_start_accepted = start_q & ~busy_i;

   // Upper write-data bits have no destination in some registers.
   assign w_unused_wdata = ^slave_writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         start_q    <= 1'b0;
         abort_q    <= 1'b0;
         irq_en_q   <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
         src_q      <= '0;
         dst_q      <= '0;
         length_q   <= '0;
         readdata_q <= '0;
      end else begin
         start_q <= w_wr_ctrl & slave_writedata[CTRL_START_BIT];
         abort_q <= w_wr_ctrl & slave_writedata[CTRL_ABORT_BIT];
         if (w_wr_ctrl) irq_en_q <= slave_writedata[CTRL_IRQ_EN_BIT];

         if (w_wr_src && !busy_i) src_q    <= slave_writedata[MASTER_ADDRESSWIDTH-1:0];
         if (w_wr_dst && !busy_i) dst_q    <= slave_writedata[MASTER_ADDRESSWIDTH-1:0];
         if (w_wr_len && !busy_i) length_q <= slave_writedata[LENWIDTH-1:0];

         // Engine-side set wins over a simultaneous host clear.
         if (set_done_i)                        done_q <= 1'b1;
         else if (w_wr_clr || w_start_accepted) done_q <= 1'b0;

         if (set_aborted_i)                     aborted_q <= 1'b1;
         else if (w_wr_clr || w_start_accepted) aborted_q <= 1'b0;

         if (w_rd) readdata_q <= readdata_d;
      end
   end

   always_comb begin
      readdata_d = '0;
      case (slave_address)
         SLAVE_ADDRESSWIDTH'(CSR_CTRL):       readdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
         SLAVE_ADDRESSWIDTH'(CSR_STATUS): begin
            readdata_d[STAT_BUSY_BIT]    = busy_i;
            readdata_d[STAT_DONE_BIT]    = done_q;
            readdata_d[STAT_ABORTED_BIT] = aborted_q;
         end
         SLAVE_ADDRESSWIDTH'(CSR_SRC):        readdata_d = DATAWIDTH'(src_q);
         SLAVE_ADDRESSWIDTH'(CSR_DST):        readdata_d = DATAWIDTH'(dst_q);
         SLAVE_ADDRESSWIDTH'(CSR_LENGTH):     readdata_d = DATAWIDTH'(length_q);
         SLAVE_ADDRESSWIDTH'(CSR_WORDS_DONE): readdata_d = DATAWIDTH'(words_done_i);
         SLAVE_ADDRESSWIDTH'(CSR_ID):         readdata_d = DATAWIDTH'(ID_VALUE);
         default:                             readdata_d = '0;
      endcase
   end

   assign slave_readdata = readdata_q;
   assign start_o        = start_q;
   assign abort_o        = abort_q;
   assign irq_o          = (done_q | aborted_q) & irq_en_q;
   assign src_o          = src_q;
   assign dst_o          = dst_q;
   assign length_o       = length_q;

endmodule : amm_copy_csr
`default_nettype wire

// File: rtl/amm_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : amm_copy_engine
//  Purpose  : CSR-programmed word-copy controller. Reads LENGTH words from
//             SRC over an Avalon-MM master and writes them to DST, one word
//             in flight at a time, then raises a level interrupt.
//  Ports    : clk, reset_n  - clock, async active-low reset
//             slave_*       - CSR window (see amm_copy_csr)
//             master_*      - Avalon-MM master (read/write, waitrequest,
//                             readdatavalid)
//             irq           - (DONE | ABORTED) & IRQ_EN
//             busy          - FSM not in IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module amm_copy_engine
   import amm_copy_pkg::*;
#(
   parameter int MASTER_ADDRESSWIDTH = 26,
   parameter int SLAVE_ADDRESSWIDTH  = 3,
   parameter int DATAWIDTH           = 32,
   parameter int LENWIDTH            = 16
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address,
   input  logic [DATAWIDTH-1:0]           slave_writedata,
   input  logic                           slave_write,
   input  logic                           slave_read,
   input  logic                           slave_chipselect,
   output logic [DATAWIDTH-1:0]           slave_readdata,
   output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
   output logic [DATAWIDTH-1:0]           master_writedata,
   output logic                           master_write,
   output logic                           master_read,
   input  logic [DATAWIDTH-1:0]           master_readdata,
   input  logic                           master_readdatavalid,
   input  logic                           master_waitrequest,
   output logic                           irq,
   output logic                           busy
);

   localparam logic [MASTER_ADDRESSWIDTH-1:0] c_STRIDE = MASTER_ADDRESSWIDTH'(DATAWIDTH / 8);

   state_t                         state_q, state_d;
   logic [MASTER_ADDRESSWIDTH-1:0] cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
   logic [LENWIDTH-1:0]            remaining_q, remaining_d;
   logic [LENWIDTH-1:0]            words_done_q, words_done_d;
   logic [DATAWIDTH-1:0]           data_q, data_d;
   logic                           abort_pend_q, abort_pend_d;

   logic                           w_start, w_abort, w_busy, w_set_done, w_set_aborted;
   logic [MASTER_ADDRESSWIDTH-1:0] w_src, w_dst;
   logic [LENWIDTH-1:0]            w_length;

   assign w_busy = (state_q != ST_IDLE);

   amm_copy_csr #(
      .MASTER_ADDRESSWIDTH (MASTER_ADDRESSWIDTH),
      .SLAVE_ADDRESSWIDTH  (SLAVE_ADDRESSWIDTH),
      .DATAWIDTH           (DATAWIDTH),
      .LENWIDTH            (LENWIDTH)
   ) u_csr (
      .clk              (clk),
      .reset_n          (reset_n),
      .slave_address    (slave_address),
      .slave_writedata  (slave_writedata),
      .slave_write      (slave_write),
      .slave_read       (slave_read),
      .slave_chipselect (slave_chipselect),
      .slave_readdata   (slave_readdata),
      .busy_i           (w_busy),
      .set_done_i       (w_set_done),
      .set_aborted_i    (w_set_aborted),
      .words_done_i     (words_done_q),
      .start_o          (w_start),
      .abort_o          (w_abort),
      .irq_o            (irq),
      .src_o            (w_src),
      .dst_o            (w_dst),
      .length_o         (w_length)
   );

   always_comb begin
      state_d       = state_q;
      cur_src_d     = cur_src_q;
      cur_dst_d     = cur_dst_q;
      remaining_d   = remaining_q;
      words_done_d  = words_done_q;
      data_d        = data_q;
      abort_pend_d  = abort_pend_q;
      w_set_done    = 1'b0;
      w_set_aborted = 1'b0;

      // An abort is only remembered here; it takes effect at the next
      // word boundary so no bus handshake is ever cut short.
      if (w_abort && w_busy) abort_pend_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (w_start) begin
               cur_src_d    = w_src;
               cur_dst_d    = w_dst;
               remaining_d  = w_length;
               words_done_d = '0;
               state_d      = (w_length == '0) ? ST_FINISH : ST_RD_REQ;
            end
         end
         ST_RD_REQ: begin
            if (!master_waitrequest) state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (master_readdatavalid) begin
               data_d  = master_readdata;
               state_d = ST_WR_REQ;
            end
         end
         ST_WR_REQ: begin
            if (!master_waitrequest) begin
               cur_src_d    = cur_src_q + c_STRIDE;
               cur_dst_d    = cur_dst_q + c_STRIDE;
               remaining_d  = remaining_q - 1'b1;
               words_done_d = words_done_q + 1'b1;
               if (remaining_q == LENWIDTH'(1)) begin
                  // An abort arriving with the final word is too late:
                  // the transfer has completed, so report DONE.
                  abort_pend_d = abort_pend_q;
                  state_d      = ST_FINISH;
               end else if (abort_pend_q || w_abort) begin
                  state_d = ST_FINISH;
               end else begin
                  state_d = ST_RD_REQ;
               end
            end
         end
         ST_FINISH: begin
            w_set_aborted = abort_pend_q;
            w_set_done    = ~abort_pend_q;
            abort_pend_d  = 1'b0;
            state_d       = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         cur_src_q    <= '0;
         cur_dst_q    <= '0;
         remaining_q  <= '0;
         words_done_q <= '0;
         data_q       <= '0;
         abort_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_src_q    <= cur_src_d;
         cur_dst_q    <= cur_dst_d;
         remaining_q  <= remaining_d;
         words_done_q <= words_done_d;
         data_q       <= data_d;
         abort_pend_q <= abort_pend_d;
      end
   end

   // Requests decode straight from the state register, so they drop the
   // moment reset is asserted and are never both high.
   assign master_read      = (state_q == ST_RD_REQ);
   assign master_write     = (state_q == ST_WR_REQ);
   assign master_address   = (state_q == ST_RD_REQ) ? cur_src_q :
                             (state_q == ST_WR_REQ) ? cur_dst_q : '0;
   assign master_writedata = data_q;
   assign busy             = w_busy;

endmodule : amm_copy_engine
`default_nettype wire

// File: tb/tb_amm_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_amm_copy_engine
//  Purpose  : Directed self-checking bench for amm_copy_engine with a small
//             Avalon-MM memory model (programmable waitrequest length and
//             read latency) and a transaction recorder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_amm_copy_engine;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  slave_address = '0;
   logic [31:0] slave_writedata = '0;
   logic        slave_write = 1'b0, slave_read = 1'b0, slave_chipselect = 1'b0;
   logic [31:0] slave_readdata;
   logic [25:0] master_address;
   logic [31:0] master_writedata, master_readdata;
   logic        master_write, master_read, master_readdatavalid, master_waitrequest;
   logic        irq, busy;

   int n_checks = 0;
   int n_errors = 0;

   amm_copy_engine dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .slave_address        (slave_address),
      .slave_writedata      (slave_writedata),
      .slave_write          (slave_write),
      .slave_read           (slave_read),
      .slave_chipselect     (slave_chipselect),
      .slave_readdata       (slave_readdata),
      .master_address       (master_address),
      .master_writedata     (master_writedata),
      .master_write         (master_write),
      .master_read          (master_read),
      .master_readdata      (master_readdata),
      .master_readdatavalid (master_readdatavalid),
      .master_waitrequest   (master_waitrequest),
      .irq                  (irq),
      .busy                 (busy)
   );

   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   function automatic logic [31:0] mem_word(input logic [25:0] a);
      return {6'h2B, a} ^ 32'h0000_A5A5;
   endfunction

   int          wait_n = 0;
   int          lat    = 1;
   int          wcnt   = 0;
   int          rd_dly = 0;
   logic        rd_pend = 1'b0;
   logic [31:0] rdata = '0;
   logic        stall_n = 1'b0, acc_rd_n = 1'b0;
   logic [25:0] acc_addr_n = '0;

   assign master_waitrequest   = (master_read | master_write) && (wcnt != wait_n);
   assign master_readdatavalid = rd_pend && (rd_dly == 0);
   assign master_readdata      = rdata;

   // recorder / protocol monitor
   logic [25:0] rd_addr_q[$];
   logic [25:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          stab_err = 0, both_err = 0, busy_cycles = 0;
   logic        prev_stall = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
   logic [25:0] prev_addr = '0;
   logic [31:0] prev_data = '0;

   always @(negedge clk) begin
      if (!reset_n) begin
         prev_stall = 1'b0;
         stall_n    = 1'b0;
         acc_rd_n   = 1'b0;
      end else begin
         if (busy) busy_cycles++;
         if (master_read && master_write) both_err++;
         if (prev_stall && (master_address != prev_addr || master_read != prev_rd ||
                            master_write != prev_wr || (prev_wr && master_writedata != prev_data)))
            stab_err++;
         stall_n    = (master_read | master_write) && master_waitrequest;
         acc_rd_n   = master_read && !master_waitrequest;
         acc_addr_n = master_address;
         if (acc_rd_n) rd_addr_q.push_back(master_address);
         if (master_write && !master_waitrequest) begin
            wr_addr_q.push_back(master_address);
            wr_data_q.push_back(master_writedata);
         end
         prev_stall = stall_n;
         prev_rd    = master_read;
         prev_wr    = master_write;
         prev_addr  = master_address;
         prev_data  = master_writedata;
      end
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wcnt    <= 0;
         rd_pend <= 1'b0;
         rd_dly  <= 0;
         rdata   <= '0;
      end else begin
         wcnt <= stall_n ? wcnt + 1 : 0;
         if (acc_rd_n) begin
            rd_pend <= 1'b1;
            rd_dly  <= lat - 1;
            rdata   <= mem_word(acc_addr_n);
         end else if (rd_pend) begin
            if (rd_dly == 0) rd_pend <= 1'b0;
            else             rd_dly  <= rd_dly - 1;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      slave_chipselect = 1'b1; slave_write = 1'b1; slave_address = a; slave_writedata = d;
      @(negedge clk);
      slave_chipselect = 1'b0; slave_write = 1'b0;
   endtask

   task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      slave_chipselect = 1'b1; slave_read = 1'b1; slave_address = a;
      @(negedge clk);
      slave_chipselect = 1'b0; slave_read = 1'b0;
      d = slave_readdata;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!busy && n < 20) begin @(negedge clk); n++; end
      n = 0;
      while (busy && n < 2000) begin @(negedge clk); n++; end
      chk({tag, "_timeout"}, 32'(busy), 32'd0);
   endtask

   task automatic clear_log();
      rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
      busy_cycles = 0;
   endtask

   task automatic check_copy(input string tag, input logic [25:0] src, input logic [25:0] dst, input int n);
      logic [25:0] sa, da;
      chk({tag, "_rd_count"}, 32'(rd_addr_q.size()), 32'(n));
      chk({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         sa = src + 26'(4 * i);
         da = dst + 26'(4 * i);
         if (i < rd_addr_q.size()) chk({tag, "_rd_addr"}, 32'(rd_addr_q[i]), 32'(sa));
         if (i < wr_addr_q.size()) begin
            chk({tag, "_wr_addr"}, 32'(wr_addr_q[i]), 32'(da));
            chk({tag, "_wr_data"}, wr_data_q[i], mem_word(sa));
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] v;
      int          n;

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_mread", 32'(master_read), 32'd0);
      chk("rst_mwrite", 32'(master_write), 32'd0);
      chk("rst_rdata", slave_readdata, 32'd0);
      reset_n = 1'b1;
      csr_read(3'd1, v); chk("rst_status", v, 32'h0);
      csr_read(3'd7, v); chk("rst_id", v, 32'hC0DE0001);
      csr_read(3'd4, v); chk("rst_length", v, 32'h0);

      // Basic copy, zero wait, latency 1
      clear_log(); wait_n = 0; lat = 1;
      csr_write(3'd2, 32'h0800_0000);
      csr_write(3'd3, 32'h0800_1000);
      csr_write(3'd4, 32'd4);
      csr_write(3'd0, 32'h5);
      wait_done("basic");
      check_copy("basic", 26'h000_0000, 26'h000_1000, 4);
      chk("basic_busy_cycles", 32'(busy_cycles), 32'd13);
      csr_read(3'd1, v); chk("basic_status", v, 32'h2);
      csr_read(3'd5, v); chk("basic_words", v, 32'd4);
      csr_read(3'd0, v); chk("basic_ctrl", v, 32'h4);
      chk("basic_irq", 32'(irq), 32'd1);
      csr_write(3'd6, 32'h0);
      chk("basic_irq_clr", 32'(irq), 32'd0);
      csr_read(3'd1, v); chk("basic_status_clr", v, 32'h0);

      // Backpressure: 3 wait cycles per request, data 6 cycles after accept
      clear_log(); wait_n = 3; lat = 6; stab_err = 0;
      csr_write(3'd2, 32'h0800_0100);
      csr_write(3'd3, 32'h0800_2000);
      csr_write(3'd4, 32'd2);
      csr_write(3'd0, 32'h5);
      wait_done("bp");
      check_copy("bp", 26'h000_0100, 26'h000_2000, 2);
      chk("bp_stable", 32'(stab_err), 32'd0);
      csr_read(3'd5, v); chk("bp_words", v, 32'd2);

      // Zero length
      clear_log(); wait_n = 0; lat = 1;
      csr_write(3'd6, 32'h0);
      csr_write(3'd4, 32'd0);
      csr_write(3'd0, 32'h5);
      @(negedge clk);
      chk("zl_irq_1cyc", 32'(irq), 32'd0);
      @(negedge clk);
      chk("zl_irq_2cyc", 32'(irq), 32'd1);
      chk("zl_rd_count", 32'(rd_addr_q.size()), 32'd0);
      chk("zl_wr_count", 32'(wr_addr_q.size()), 32'd0);
      csr_read(3'd5, v); chk("zl_words", v, 32'd0);
      csr_read(3'd1, v); chk("zl_status", v, 32'h2);

      // Abort during the 3rd word's read
      clear_log(); wait_n = 0; lat = 4;
      csr_write(3'd2, 32'h0800_0000);
      csr_write(3'd3, 32'h0800_3000);
      csr_write(3'd4, 32'd100);
      csr_write(3'd0, 32'h5);
      n = 0;
      while (rd_addr_q.size() < 3 && n < 500) begin @(negedge clk); n++; end
      chk("ab_reach3", 32'(rd_addr_q.size()), 32'd3);
      csr_write(3'd0, 32'h6);
      wait_done("ab");
      check_copy("ab", 26'h000_0000, 26'h000_3000, 3);
      csr_read(3'd1, v); chk("ab_status", v, 32'h4);
      csr_read(3'd5, v); chk("ab_words", v, 32'd3);
      chk("ab_irq", 32'(irq), 32'd1);
      csr_write(3'd6, 32'h0);

      // Abort while idle has no effect; busy lockout; destination wrap
      clear_log(); wait_n = 3; lat = 2;
      csr_write(3'd0, 32'h6);
      csr_write(3'd2, 32'h0000_0100);
      csr_write(3'd3, 32'h03FF_FFFC);
      csr_write(3'd4, 32'd2);
      csr_write(3'd0, 32'h5);
      n = 0;
      while (!busy && n < 20) begin @(negedge clk); n++; end
      csr_write(3'd2, 32'h0);
      csr_write(3'd4, 32'd50);
      csr_write(3'd0, 32'h5);
      wait_done("lk");
      repeat (4) @(negedge clk);
      chk("lk_busy_after", 32'(busy), 32'd0);
      check_copy("lk", 26'h000_0100, 26'h3FF_FFFC, 2);
      csr_read(3'd2, v); chk("lk_src", v, 32'h100);
      csr_read(3'd4, v); chk("lk_length", v, 32'd2);
      csr_read(3'd5, v); chk("lk_words", v, 32'd2);
      csr_read(3'd1, v); chk("lk_status", v, 32'h2);

      // Async reset in the middle of a write request
      clear_log(); wait_n = 3; lat = 1;
      csr_write(3'd4, 32'd4);
      csr_write(3'd0, 32'h5);
      n = 0;
      while (!master_write && n < 200) begin @(negedge clk); n++; end
      chk("ar_reach_wr", 32'(master_write), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_mwrite", 32'(master_write), 32'd0);
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_irq", 32'(irq), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      csr_read(3'd1, v); chk("ar_status", v, 32'h0);
      csr_read(3'd7, v); chk("ar_id", v, 32'hC0DE0001);
      csr_read(3'd3, v); chk("ar_dst", v, 32'h0);

      chk("proto_rd_wr_excl", 32'(both_err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_amm_copy_engine
`default_nettype wire
